// File: rtl/seg_pkg.sv
// Shared 7-segment constants: digit patterns, digit slot indices and scan FSM states.
// Used by the scan driver and the score formatter.
package seg_pkg;

  localparam logic [6:0] SEG_ZERO = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  localparam logic [1:0] DIG_SCORE_ONES = 2'd0;
  localparam logic [1:0] DIG_SCORE_TENS = 2'd1;
  localparam logic [1:0] DIG_HIGH_ONES  = 2'd2;
  localparam logic [1:0] DIG_HIGH_TENS  = 2'd3;

  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [6:0] CATH_OFF = 7'b1111111;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low one-cold anode select for a digit slot.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Segment bundle / display pin bundle between the score formatter side and the scan driver.
// master drives the segment inputs and controls, slave is the scan driver.
interface seg_scan_driver_if;

  logic [13:0] seg;
  logic [13:0] seg_high;
  logic        update;
  logic        blank_lz;
  logic        blink_high;
  logic [3:0]  an;
  logic [6:0]  cath;
  logic        dp;
  logic [1:0]  digit_idx;

  modport master (
    output seg, seg_high, update, blank_lz, blink_high,
    input  an, cath, dp, digit_idx
  );

  modport slave (
    input  seg, seg_high, update, blank_lz, blink_high,
    output an, cath, dp, digit_idx
  );

endinterface

// File: rtl/seg_cath_map.sv
// Active-high a..g pattern (bit 6 = a) to active-low cathode pins (cath[0] = a).
// Pure bit reverse plus invert; no pattern validation.
module seg_cath_map
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [6:0] cath_o
);

  for (genvar i = 0; i < 7; i++) begin : g_bit
    assign cath_o[i] = ~pattern_i[6-i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: snapshot on update, guard/drive scan per digit,
// leading-zero blanking of tens digits and blinking of the high-score pair.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 1000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_driver_if.slave   bus
);

  localparam int unsigned CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BLK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);

  scan_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        idx_q;
  logic [3:0]        an_q;
  logic [6:0]        cath_q;
  logic              dp_q;

  logic [27:0]       snap_q;
  logic [27:0]       snap_d;
  logic [BLK_W-1:0]  blink_cnt_q;
  logic [BLK_W-1:0]  blink_cnt_d;
  logic              blink_on_q;
  logic              blink_on_d;

  logic [6:0]        digit_pat_s;
  logic [6:0]        drive_pat_s;
  logic [6:0]        mapped_s;
  logic [3:0]        an_sel_s;
  logic              blank_s;
  logic              lz_tens_s;
  logic              lz_high_tens_s;
  logic              blink_off_s;

  // Snapshot and blink next-state.
  always_comb begin
    snap_d      = snap_q;
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    blink_on_d  = blink_on_q;
    if (bus.update) begin
      snap_d = {bus.seg_high, bus.seg};
    end else begin
      snap_d = snap_q;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
      blink_on_d  = blink_on_q;
    end
  end

  // Snapshot register and free-running blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q      <= {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO};
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign lz_tens_s      = bus.blank_lz && (snap_q[13:7] == SEG_ZERO);
  assign lz_high_tens_s = bus.blank_lz && (snap_q[27:21] == SEG_ZERO);
  assign blink_off_s    = bus.blink_high && !blink_on_q;

  // Pattern and blank decision for the digit about to be driven.
  always_comb begin
    digit_pat_s = SEG_OFF;
    blank_s     = 1'b1;
    case (idx_q)
      DIG_SCORE_ONES: begin
        digit_pat_s = snap_q[6:0];
        blank_s     = 1'b0;
      end
      DIG_SCORE_TENS: begin
        digit_pat_s = snap_q[13:7];
        blank_s     = lz_tens_s;
      end
      DIG_HIGH_ONES: begin
        digit_pat_s = snap_q[20:14];
        blank_s     = blink_off_s;
      end
      DIG_HIGH_TENS: begin
        digit_pat_s = snap_q[27:21];
        blank_s     = lz_high_tens_s || blink_off_s;
      end
      default: begin
        digit_pat_s = SEG_OFF;
        blank_s     = 1'b1;
      end
    endcase
    if (blank_s) begin
      drive_pat_s = SEG_OFF;
      an_sel_s    = AN_OFF;
    end else begin
      drive_pat_s = digit_pat_s;
      an_sel_s    = anode_sel(idx_q);
    end
  end

  seg_cath_map u_cath_map (
    .pattern_i (drive_pat_s),
    .cath_o    (mapped_s)
  );

  // Scan FSM; an/cath only ever change on GUARD/DRIVE transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= DIG_SCORE_ONES;
      an_q    <= AN_OFF;
      cath_q  <= CATH_OFF;
      dp_q    <= 1'b1;
    end else begin
      dp_q <= 1'b1;
      case (state_q)
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            an_q    <= an_sel_s;
            cath_q  <= mapped_s;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == DIGIT_LAST) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= idx_q + 2'd1;
            an_q    <= AN_OFF;
            cath_q  <= CATH_OFF;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= GUARD;
          cnt_q   <= '0;
          an_q    <= AN_OFF;
          cath_q  <= CATH_OFF;
        end
      endcase
    end
  end

  assign bus.an        = an_q;
  assign bus.cath      = cath_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: edge-indexed behavioural model checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int G  = 2;
  localparam int B  = 32;
  localparam int P  = D + G;
  localparam int HN = 4096;
  localparam logic [6:0] ZERO7 = 7'b1111110;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seg_scan_driver_if bus();

  seg_scan_driver #(
    .DIGIT_CYCLES (D),
    .GUARD_CYCLES (G),
    .BLINK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model state: edges since reset release, and inputs as seen at each edge.
  int          e;
  logic [27:0] m_snap;
  logic [27:0] snap_h [HN];
  logic        blz_h  [HN];
  logic        bh_h   [HN];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e      <= 0;
      m_snap <= {ZERO7, ZERO7, ZERO7, ZERO7};
    end else begin
      if (e + 1 < HN) begin
        snap_h[e+1] <= m_snap;
        blz_h[e+1]  <= bus.blank_lz;
        bh_h[e+1]   <= bus.blink_high;
      end
      e <= e + 1;
      if (bus.update) m_snap <= {bus.seg_high, bus.seg};
    end
  end

  // Expected outputs after edge ee, derived from scan position and entry-edge inputs.
  task automatic expect_at(input int ee, output logic [3:0] ea, output logic [6:0] ec,
                           output logic [1:0] ei);
    int k, slot, di, ent;
    logic [6:0] pat;
    logic off;
    ea = 4'b1111;
    ec = 7'b1111111;
    ei = 2'd0;
    if (ee >= G) begin
      k    = ee - G;
      slot = k / P;
      di   = slot % 4;
      if ((k % P) < D) begin
        ei  = di[1:0];
        ent = G + slot * P;
        pat = snap_h[ent][7*di +: 7];
        off = 1'b0;
        if ((di == 1 || di == 3) && blz_h[ent] && pat == ZERO7) off = 1'b1;
        if (di >= 2 && bh_h[ent] && (((ent - 1) / B) % 2 == 1)) off = 1'b1;
        if (!off) begin
          ea[di] = 1'b0;
          for (int i = 0; i < 7; i++) ec[i] = ~pat[6-i];
        end
      end else begin
        ei = 2'((di + 1) % 4);
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] ec;
    logic [1:0] ei;
    if (reset) begin
      chk("rst_an", bus.an, 4'b1111);
      chk("rst_cath", bus.cath, 7'b1111111);
      chk("rst_idx", bus.digit_idx, 2'd0);
      chk("rst_dp", bus.dp, 1'b1);
    end else if (e < HN) begin
      expect_at(e, ea, ec, ei);
      chk("model_an", bus.an, ea);
      chk("model_cath", bus.cath, ec);
      chk("model_idx", bus.digit_idx, ei);
      chk("model_dp", bus.dp, 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: async reset between edges, then release with optional update.
  // Returns at the negedge after the first post-release edge.
  task automatic restart(input logic do_upd, input logic [13:0] s, input logic [13:0] sh);
    #2 reset = 1'b1;
    #1;
    chk("async_an", bus.an, 4'b1111);
    chk("async_cath", bus.cath, 7'b1111111);
    chk("async_idx", bus.digit_idx, 2'd0);
    tick(2);
    reset        = 1'b0;
    bus.seg      = s;
    bus.seg_high = sh;
    bus.update   = do_upd;
    tick(1);
    bus.update   = 1'b0;
  endtask

  localparam logic [13:0] S42  = {7'b0110011, 7'b1101101};
  localparam logic [13:0] S07  = {7'b1111110, 7'b1110000};
  localparam logic [13:0] SNEW = {7'b1111001, 7'b0110000};
  localparam logic [13:0] SHI  = {7'b1011011, 7'b0110000};

  initial begin
    reset          = 1'b1;
    bus.seg        = '0;
    bus.seg_high   = '0;
    bus.update     = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.blink_high = 1'b0;
    tick(1);

    // Scenario 1: score 42.
    restart(1'b1, S42, SHI);
    tick(1);
    chk("s1_an_d0", bus.an, 4'b1110);
    chk("s1_cath_d0", bus.cath, 7'b0100100);
    tick(3);
    chk("s1_cath_d0_hold", bus.cath, 7'b0100100);
    tick(1);
    chk("s1_guard_an", bus.an, 4'b1111);
    chk("s1_guard_cath", bus.cath, 7'b1111111);
    tick(2);
    chk("s1_an_d1", bus.an, 4'b1101);
    chk("s1_cath_d1", bus.cath, 7'b0011001);

    // Scenario 2: anode rotation every P clocks.
    restart(1'b1, S42, SHI);
    tick(1);
    for (int s = 0; s < 6; s++) begin
      chk("s2_an", bus.an, {28'd0, ~(4'b0001 << (s % 4))});
      chk("s2_idx", bus.digit_idx, s % 4);
      tick(P);
    end

    // Scenario 3: leading-zero blanking of digit 1.
    bus.blank_lz = 1'b1;
    restart(1'b1, S07, SHI);
    tick(7);
    chk("s3_blank_an", bus.an, 4'b1111);
    chk("s3_blank_cath", bus.cath, 7'b1111111);
    chk("s3_blank_idx", bus.digit_idx, 2'd1);
    tick(1);
    bus.blank_lz = 1'b0;
    tick(23);
    chk("s3_show_an", bus.an, 4'b1101);
    chk("s3_show_cath", bus.cath, 7'b1000000);

    // Scenario 4: update one clock into digit 0's DRIVE.
    restart(1'b1, S42, SHI);
    tick(1);
    bus.seg    = SNEW;
    bus.update = 1'b1;
    tick(1);
    bus.update = 1'b0;
    chk("s4_old_hold", bus.cath, 7'b0100100);
    tick(2);
    chk("s4_old_last", bus.cath, 7'b0100100);
    tick(3);
    chk("s4_new_tens", bus.cath, 7'b0110000);
    tick(18);
    chk("s4_new_ones", bus.cath, 7'b1111001);

    // Scenario 5: blinking of digits 2/3.
    bus.blink_high = 1'b1;
    restart(1'b1, S42, SHI);
    tick(13);
    chk("s5_d2_on", bus.an, 4'b1011);
    tick(6);
    chk("s5_d3_on", bus.an, 4'b0111);
    tick(18);
    chk("s5_d2_off", bus.an, 4'b1111);
    tick(12);
    chk("s5_d0_unaffected", bus.an, 4'b1110);
    tick(36);
    chk("s5_d2_on_again", bus.an, 4'b1011);
    tick(80);
    bus.blink_high = 1'b0;

    // Scenario 6: reset mid-DRIVE clears the snapshot, then a normal restart.
    restart(1'b1, S42, SHI);
    tick(2);
    chk("s6_pre_an", bus.an, 4'b1110);
    restart(1'b0, S42, SHI);
    tick(1);
    chk("s6_zero_snap", bus.cath, 7'b1000000);
    tick(1);
    restart(1'b1, S42, SHI);
    tick(1);
    chk("s6_restart_an", bus.an, 4'b1110);
    chk("s6_restart_cath", bus.cath, 7'b0100100);
    tick(6);
    chk("s6_restart_d1", bus.cath, 7'b0011001);

    // Randomized traffic checked by the model.
    restart(1'b1, S42, SHI);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.update = ($urandom_range(7) == 0);
      if (bus.update) begin
        bus.seg[6:0]       = 7'($urandom);
        bus.seg[13:7]      = ($urandom_range(1) == 0) ? ZERO7 : 7'($urandom);
        bus.seg_high[6:0]  = 7'($urandom);
        bus.seg_high[13:7] = ($urandom_range(1) == 0) ? ZERO7 : 7'($urandom);
      end
      if ($urandom_range(19) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(29) == 0) bus.blink_high = ~bus.blink_high;
    end
    bus.update = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It consumes the two 14-bit segment bundles produced by the score formatter: current score in `seg`, high score in `seg_high`, each `{tens[6:0], ones[6:0]}` with bit 6 = segment a … bit 0 = segment g, active-high. It snapshots them on an update strobe and scans one digit at a time with a blank guard interval between digits. It also performs physical remapping, leading-zero blanking of the tens digits and optional blinking of the high-score digits.

## Interface
- `DIGIT_CYCLES`, default 100000: clocks each digit is driven (1 ms at 100 MHz).
- `GUARD_CYCLES`, default 1000: clocks of all-off between digits (anti-ghosting); must be ≥1.
- `BLINK_CYCLES`, default 25000000: clocks per blink half-period.
- `clk` input 1: system clock; the block uses this one clock only.
- `reset` input 1: asynchronous, active-high.
- `seg` input 14: current-score segment patterns `{tens, ones}`.
- `seg_high` input 14: high-score segment patterns `{tens, ones}`.
- `update` input 1: one-cycle strobe; captures `seg`/`seg_high` into the snapshot.
- `blank_lz` input 1: enable leading-zero blanking of both tens digits.
- `blink_high` input 1: blink digits 2 and 3.
- `an` output 4: anodes, active-low; `an[0]` is rightmost.
- `cath` output 7: cathodes, active-low; `cath[0]`=a … `cath[6]`=g.
- `dp` output 1: decimal point, active-low; held 1.
- `digit_idx` output 2: digit currently being scanned.

## Operation
- Digit map: 0 = `seg[6:0]`, 1 = `seg[13:7]`, 2 = `seg_high[6:0]`, 3 = `seg_high[13:7]`.
- Snapshot: 28-bit register loaded on the edge where `update`=1. Reset value is all four digits = `SEG_ZERO` (7'b1111110).
- Cathode map: `cath[i] = ~pattern[6-i]`. Input patterns are not validated; any 7-bit pattern is passed through.
- FSM has two states, GUARD and DRIVE. Each state lasts exactly its parameter count of cycles.
- GUARD: `an`=4'b1111, `cath`=7'b1111111.
- GUARD→DRIVE on count expiry. At the DRIVE entry edge the block evaluates the blank condition for `digit_idx` and loads `an`/`cath`.
- DRIVE, not blanked: `an` has only bit `digit_idx` low, and `cath` is the mapped snapshot digit.
- DRIVE, blanked: `an`=4'b1111 and `cath`=7'b1111111.
- DRIVE→GUARD on count expiry. `digit_idx` increments at that edge and wraps 3→0.
- Blank condition for digit 1: `blank_lz` and the snapshot tens digit equals `SEG_ZERO`. The same rule applies to digit 3.
- Blank condition for digits 2 and 3 (additionally): `blink_high` and blink phase = off.
- Blink: free-running counter with a phase bit that toggles every `BLINK_CYCLES`. Reset phase = on.
- Outputs are registered; there is no combinational path from input to output.

## Timing
- Reset values: `an`=4'b1111, `cath`=7'b1111111, `dp`=1, `digit_idx`=0, FSM=GUARD, counters=0, blink phase on.
- First DRIVE begins `GUARD_CYCLES` edges after reset deasserts.
- Full scan period: 4·(`GUARD_CYCLES`+`DIGIT_CYCLES`) clocks.
- The displayed value never changes mid-digit. `cath`/`an` change only at GUARD/DRIVE transitions.
- Update latency: `update` asserted in the same cycle as a DRIVE entry edge does not affect that digit. The new snapshot is used from the next DRIVE entry onward.
- `blank_lz`/`blink_high`/blink phase are sampled only at DRIVE entry. A change during DRIVE takes effect at the next digit.
- Reset asserted mid-DRIVE: all outputs go to their reset values asynchronously and the snapshot returns to zeros.

## Structure
- Package `seg_pkg` holds:
  - `SEG_ZERO` = 7'b1111110 and `SEG_OFF` = 7'b0000000.
  - Digit index constants `DIG_SCORE_ONES`…`DIG_HIGH_TENS`.
  - State enum {GUARD, DRIVE}.
  - These are shared with the score formatter.
- Sub-module `seg_cath_map`: combinational 7-bit pattern → active-low cathode remap (bit reverse plus invert), reused by any future display block.

## Test plan
All scenarios use `DIGIT_CYCLES`=4, `GUARD_CYCLES`=2, `BLINK_CYCLES`=32.
1. Reset, then `update` with score 42 (`seg`={0110011,1101101}) → after 2 clocks `an`=1110, `cath`=0100100 for 4 clocks; then 2 clocks all-off; then `an`=1101, `cath`=0011001.
2. Free run → `an` low pattern cycles 1110, 1101, 1011, 0111, repeating every 24 clocks, with `digit_idx` matching.
3. Score 07 with `blank_lz`=1 → digit 1 slot shows `an`=1111; with `blank_lz`=0 it shows `an`=1101, `cath`=1000000.
4. `update` to a new value 1 clock into digit 0's DRIVE → `cath` holds the old value for the remaining 3 clocks; the new value appears at digit 1's DRIVE entry.
5. `blink_high`=1 → digits 2/3 are driven for 32 clocks, blanked for 32 clocks, alternating; digits 0/1 are unaffected.
6. Assert `reset` mid-DRIVE → outputs go to 1111/1111111 in the same cycle with no clock edge, and the restart behaviour matches scenario 1.
